// File: rtl/activation_relu_sequencer.sv
// Element-wise ReLU sequencer: walks a CHANNELS x ROWS x COLS feature map held in a read buffer,
// clamps negative words to zero (unless bypassed) and streams them out through a 2-entry FIFO.
module activation_relu_sequencer #(
   parameter int unsigned BITWIDTH = 32,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned ROWS     = 10,
   parameter int unsigned COLS     = 10,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned CNT_W    = 8,
   localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                bypass,
   output logic                busy,
   output logic                done,
   output logic                rd_en,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [BITWIDTH-1:0] rd_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITWIDTH-1:0] out_data,
   output logic [CH_W-1:0]     out_ch,
   output logic [ROW_W-1:0]    out_row,
   output logic [COL_W-1:0]    out_col,
   output logic                out_last,
   output logic [CNT_W-1:0]    neg_count
);
   localparam int unsigned TOTAL = CHANNELS * ROWS * COLS;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   typedef struct packed {
      logic [BITWIDTH-1:0] data;
      logic [CH_W-1:0]     ch;
      logic [ROW_W-1:0]    row;
      logic [COL_W-1:0]    col;
      logic                last;
   } entry_t;

   state_e             state_q, state_d;
   logic [CH_W-1:0]    ch_q;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   col_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               bypass_q;
   logic [CNT_W-1:0]   neg_q;

   // Index of the read whose data arrives on rd_data this cycle
   logic               infl_q;
   logic [CH_W-1:0]    infl_ch_q;
   logic [ROW_W-1:0]   infl_row_q;
   logic [COL_W-1:0]   infl_col_q;
   logic               infl_last_q;

   entry_t             fifo_q [2];
   logic               wptr_q, rptr_q;
   logic [1:0]         cnt_q;

   logic               start_acc, pop, push, last_addr, col_wrap, row_wrap, clamp;
   logic [1:0]         occ;
   entry_t             head, wr_entry;

   always_comb begin
      start_acc = (state_q == StIdle) && start;
      head      = fifo_q[rptr_q];
      pop       = (cnt_q != 2'd0) && out_ready;
      push      = infl_q;
      last_addr = (addr_q == ADDR_W'(TOTAL - 1));
      col_wrap  = (col_q == COL_W'(COLS - 1));
      row_wrap  = (row_q == ROW_W'(ROWS - 1));
      // Entries held or in flight after this cycle's pop; a new read must still fit
      occ       = cnt_q + {1'b0, infl_q} - {1'b0, pop};
      rd_en     = (state_q == StRun) && (occ < 2'd2);
      clamp     = !bypass_q && rd_data[BITWIDTH-1];
      wr_entry.data = clamp ? '0 : rd_data;
      wr_entry.ch   = infl_ch_q;
      wr_entry.row  = infl_row_q;
      wr_entry.col  = infl_col_q;
      wr_entry.last = infl_last_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (rd_en && last_addr) state_d = StDrain;
         StDrain: if (pop && head.last) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q     <= '0;
         row_q    <= '0;
         col_q    <= '0;
         addr_q   <= '0;
         bypass_q <= 1'b0;
      end else if (start_acc) begin
         ch_q     <= '0;
         row_q    <= '0;
         col_q    <= '0;
         addr_q   <= '0;
         bypass_q <= bypass;
      end else if (rd_en) begin
         addr_q <= addr_q + ADDR_W'(1);
         if (col_wrap) begin
            col_q <= '0;
            if (row_wrap) begin
               row_q <= '0;
               ch_q  <= ch_q + CH_W'(1);
            end else begin
               row_q <= row_q + ROW_W'(1);
            end
         end else begin
            col_q <= col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         infl_q      <= 1'b0;
         infl_ch_q   <= '0;
         infl_row_q  <= '0;
         infl_col_q  <= '0;
         infl_last_q <= 1'b0;
      end else begin
         infl_q <= rd_en;
         if (rd_en) begin
            infl_ch_q   <= ch_q;
            infl_row_q  <= row_q;
            infl_col_q  <= col_q;
            infl_last_q <= last_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wptr_q    <= 1'b0;
         rptr_q    <= 1'b0;
         cnt_q     <= 2'd0;
      end else begin
         if (push) begin
            fifo_q[wptr_q] <= wr_entry;
            wptr_q         <= ~wptr_q;
         end
         if (pop) begin
            rptr_q <= ~rptr_q;
         end
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= '0;
      end else if (start_acc) begin
         neg_q <= '0;
      end else if (push && clamp) begin
         neg_q <= neg_q + CNT_W'(1);
      end
   end

   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      rd_addr   = addr_q;
      out_valid = (cnt_q != 2'd0);
      out_data  = head.data;
      out_ch    = head.ch;
      out_row   = head.row;
      out_col   = head.col;
      out_last  = out_valid && head.last;
      neg_count = neg_q;
   end

endmodule

// File: tb/tb_activation_relu_sequencer.sv
// Self-checking bench for activation_relu_sequencer: buffer model, scoreboard of expected
// elements, per-scenario tasks.
module tb_activation_relu_sequencer;
   localparam int N = 200;

   typedef struct packed {
      logic [31:0] data;
      logic [0:0]  ch;
      logic [3:0]  row;
      logic [3:0]  col;
      logic        last;
   } elem_t;

   logic        clk = 1'b0;
   logic        rst_n, start, bypass, out_ready;
   logic        busy, done, rd_en, out_valid, out_last;
   logic [7:0]  rd_addr, neg_count;
   logic [31:0] rd_data, out_data;
   logic [0:0]  out_ch;
   logic [3:0]  out_row, out_col;

   always #5 clk = ~clk;

   activation_relu_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bypass    (bypass),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .neg_count (neg_count)
   );

   logic [31:0] buffer [256];
   always @(posedge clk) if (rd_en) rd_data <= buffer[rd_addr];

   int    n_cmp = 0;
   int    n_err = 0;
   elem_t exp_q[$];
   elem_t got_q[$];
   int    first_valid_k, rd_en_k0, done_cnt, done_k, last_hs_k;
   int    unstable, ovf, stall_valid, timed_out;

   task automatic load_ramp();
      for (int a = 0; a < 256; a++) buffer[a] = 32'(a) - 32'd100;
   endtask

   task automatic push_expected(input logic byp);
      elem_t e;
      exp_q.delete();
      for (int a = 0; a < N; a++) begin
         e.data = (!byp && buffer[a][31]) ? 32'd0 : buffer[a];
         e.ch   = 1'(a / 100);
         e.row  = 4'((a % 100) / 10);
         e.col  = 4'(a % 10);
         e.last = (a == N - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic do_start(input logic byp);
      @(negedge clk);
      start  = 1'b1;
      bypass = byp;
      @(negedge clk);
      start  = 1'b0;
      bypass = ~byp;
   endtask

   // Runs one pass from the cycle after the start edge; k counts edges since that edge.
   task automatic collect(input int mode, input int start_k, input int rst_at);
      elem_t cur, prev;
      int    k, left, outstanding, after;
      bit    stall_used, stalling, prev_hold, pop;
      got_q.delete();
      first_valid_k = -1; rd_en_k0 = 0; done_cnt = 0; done_k = -1; last_hs_k = -1;
      unstable = 0; ovf = 0; stall_valid = 0; timed_out = 0;
      outstanding = 0; left = 0; after = 0; stall_used = 0; prev_hold = 0;
      prev = '0;
      for (k = 0; k < 3000; k++) begin
         stalling = 1'b0;
         if (mode == 1) begin
            if (!stall_used && got_q.size() == 57) begin
               left = 20;
               stall_used = 1'b1;
            end
            if (left > 0) begin
               out_ready = 1'b0;
               stalling  = 1'b1;
               left--;
            end else begin
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end else begin
            out_ready = 1'b1;
         end
         start = (k == start_k);
         #1;
         cur = {out_data, out_ch, out_row, out_col, out_last};
         if (k == 0) rd_en_k0 = int'(rd_en);
         if (prev_hold && (!out_valid || cur !== prev)) unstable++;
         if (stalling && out_valid) stall_valid++;
         if (out_valid && first_valid_k < 0) first_valid_k = k;
         pop = out_valid && out_ready;
         if (rd_en && (outstanding - int'(pop)) >= 2) ovf++;
         outstanding += int'(rd_en) - int'(pop);
         if (pop) begin
            got_q.push_back(cur);
            if (out_last) last_hs_k = k;
         end
         if (done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         prev_hold = out_valid && !out_ready;
         prev      = cur;
         if (rst_at >= 0 && got_q.size() == rst_at) break;
         if (done_k >= 0) begin
            after++;
            if (after > 5) break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (k >= 3000) timed_out = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; bypass = 1'b0; out_ready = 1'b0;
      #12;
      n_cmp++;
      if ({busy, done, rd_en, out_valid, out_last} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b, required 00000", {busy, done, rd_en, out_valid, out_last});
      end
      n_cmp++;
      if ({rd_addr, out_data, out_ch, out_row, out_col, neg_count} !== '0) begin
         n_err++;
         $display("FAIL reset_values: addr %h data %h ch %h row %h col %h neg %h, required 0",
                  rd_addr, out_data, out_ch, out_row, out_col, neg_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         n_err++;
         $display("FAIL idle_no_start: busy %b rd_en %b, required 0 0", busy, rd_en);
      end
   endtask

   task automatic test_relu();
      elem_t e, g;
      load_ramp();
      push_expected(1'b0);
      do_start(1'b0);
      collect(0, -1, -1);
      n_cmp++;
      if (timed_out !== 0) begin n_err++; $display("FAIL relu_timeout: got %0d, required 0", timed_out); end
      n_cmp++;
      if (rd_en_k0 !== 1) begin n_err++; $display("FAIL relu_first_rd_en: got %0d, required 1", rd_en_k0); end
      n_cmp++;
      if (first_valid_k !== 2) begin
         n_err++; $display("FAIL relu_first_valid: got %0d, required 2", first_valid_k);
      end
      n_cmp++;
      if (got_q.size() !== N) begin n_err++; $display("FAIL relu_count: got %0d, required %0d", got_q.size(), N); end
      for (int i = 0; i < N; i++) begin
         e = exp_q.pop_front();
         g = 'x;
         if (i < got_q.size()) g = got_q[i];
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL relu_elem[%0d]: got %h, required %h", i, g, e); end
      end
      n_cmp++;
      if (last_hs_k !== 201) begin n_err++; $display("FAIL relu_last_k: got %0d, required 201", last_hs_k); end
      n_cmp++;
      if (done_k !== last_hs_k + 1) begin
         n_err++; $display("FAIL relu_done_k: got %0d, required %0d", done_k, last_hs_k + 1);
      end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL relu_done_cnt: got %0d, required 1", done_cnt); end
      n_cmp++;
      if (neg_count !== 8'd100) begin n_err++; $display("FAIL relu_neg: got %0d, required 100", neg_count); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL relu_busy_end: got %b, required 0", busy); end
   endtask

   task automatic test_bypass();
      elem_t e, g;
      load_ramp();
      push_expected(1'b1);
      do_start(1'b1);
      collect(0, -1, -1);
      n_cmp++;
      if (got_q.size() !== N) begin n_err++; $display("FAIL byp_count: got %0d, required %0d", got_q.size(), N); end
      for (int i = 0; i < N; i++) begin
         e = exp_q.pop_front();
         g = 'x;
         if (i < got_q.size()) g = got_q[i];
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL byp_elem[%0d]: got %h, required %h", i, g, e); end
      end
      n_cmp++;
      if (neg_count !== 8'd0) begin n_err++; $display("FAIL byp_neg: got %0d, required 0", neg_count); end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL byp_done_cnt: got %0d, required 1", done_cnt); end
   endtask

   task automatic test_backpressure();
      elem_t e, g;
      load_ramp();
      push_expected(1'b0);
      do_start(1'b0);
      collect(1, -1, -1);
      n_cmp++;
      if (timed_out !== 0) begin n_err++; $display("FAIL bp_timeout: got %0d, required 0", timed_out); end
      n_cmp++;
      if (got_q.size() !== N) begin n_err++; $display("FAIL bp_count: got %0d, required %0d", got_q.size(), N); end
      for (int i = 0; i < N; i++) begin
         e = exp_q.pop_front();
         g = 'x;
         if (i < got_q.size()) g = got_q[i];
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL bp_elem[%0d]: got %h, required %h", i, g, e); end
      end
      n_cmp++;
      if (unstable !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes, required 0", unstable); end
      n_cmp++;
      if (ovf !== 0) begin n_err++; $display("FAIL bp_overissue: got %0d reads, required 0", ovf); end
      n_cmp++;
      if (stall_valid !== 20) begin
         n_err++; $display("FAIL bp_stall_valid: got %0d, required 20", stall_valid);
      end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done_cnt: got %0d, required 1", done_cnt); end
      n_cmp++;
      if (neg_count !== 8'd100) begin n_err++; $display("FAIL bp_neg: got %0d, required 100", neg_count); end
   endtask

   task automatic test_boundary();
      elem_t e, g;
      for (int a = 0; a < 256; a++) buffer[a] = 32'(a);
      buffer[0] = 32'h8000_0000;
      buffer[1] = 32'hFFFF_FFFF;
      buffer[2] = 32'h0000_0000;
      buffer[3] = 32'h7FFF_FFFF;
      push_expected(1'b0);
      do_start(1'b0);
      collect(0, -1, -1);
      n_cmp++;
      if (got_q.size() !== N) begin n_err++; $display("FAIL bnd_count: got %0d, required %0d", got_q.size(), N); end
      for (int i = 0; i < N; i++) begin
         e = exp_q.pop_front();
         g = 'x;
         if (i < got_q.size()) g = got_q[i];
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL bnd_elem[%0d]: got %h, required %h", i, g, e); end
      end
      n_cmp++;
      if (neg_count !== 8'd2) begin n_err++; $display("FAIL bnd_neg: got %0d, required 2", neg_count); end
   endtask

   task automatic test_start_ignored();
      elem_t e, g;
      load_ramp();
      push_expected(1'b1);
      do_start(1'b1);
      collect(0, 50, -1);
      n_cmp++;
      if (got_q.size() !== N) begin n_err++; $display("FAIL ign_count: got %0d, required %0d", got_q.size(), N); end
      for (int i = 0; i < N; i++) begin
         e = exp_q.pop_front();
         g = 'x;
         if (i < got_q.size()) g = got_q[i];
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL ign_elem[%0d]: got %h, required %h", i, g, e); end
      end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL ign_done_cnt: got %0d, required 1", done_cnt); end
      n_cmp++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         n_err++; $display("FAIL ign_idle_end: busy %b rd_en %b, required 0 0", busy, rd_en);
      end
   endtask

   task automatic test_reset_mid_pass();
      elem_t e, g;
      int    seen_done;
      load_ramp();
      push_expected(1'b0);
      do_start(1'b0);
      collect(0, -1, 120);
      n_cmp++;
      if (got_q.size() !== 120) begin n_err++; $display("FAIL rst_reach: got %0d, required 120", got_q.size()); end
      n_cmp++;
      if (neg_count !== 8'd100) begin n_err++; $display("FAIL rst_pre_neg: got %0d, required 100", neg_count); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, rd_en, out_valid, out_last} !== 5'b0) begin
         n_err++;
         $display("FAIL rst_mid_flags: got %b, required 00000", {busy, done, rd_en, out_valid, out_last});
      end
      n_cmp++;
      if ({rd_addr, out_data, out_ch, out_row, out_col, neg_count} !== '0) begin
         n_err++;
         $display("FAIL rst_mid_values: addr %h data %h ch %h row %h col %h neg %h, required 0",
                  rd_addr, out_data, out_ch, out_row, out_col, neg_count);
      end
      seen_done = 0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (done) seen_done++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (done || busy) seen_done++;
      end
      n_cmp++;
      if (seen_done !== 0) begin n_err++; $display("FAIL rst_no_done: got %0d, required 0", seen_done); end
      push_expected(1'b0);
      do_start(1'b0);
      collect(0, -1, -1);
      n_cmp++;
      if (got_q.size() !== N) begin n_err++; $display("FAIL rst_count: got %0d, required %0d", got_q.size(), N); end
      for (int i = 0; i < N; i++) begin
         e = exp_q.pop_front();
         g = 'x;
         if (i < got_q.size()) g = got_q[i];
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL rst_elem[%0d]: got %h, required %h", i, g, e); end
      end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL rst_done_cnt: got %0d, required 1", done_cnt); end
      n_cmp++;
      if (neg_count !== 8'd100) begin n_err++; $display("FAIL rst_neg: got %0d, required 100", neg_count); end
   endtask

   initial begin
      test_reset();
      test_relu();
      test_bypass();
      test_backpressure();
      test_boundary();
      test_start_ignored();
      test_reset_mid_pass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
